// File: rtl/johnson_phase_monitor.sv
// Decodes an N-stage Johnson counter state into a one-hot/binary phase, tracks step order and locks.
// Optional bad-event counter on err_cnt is built when JOHNSON_ERR_CNT_EN is defined.
module johnson_phase_monitor #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 4,
  parameter int IW       = $clog2(2*N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    q,
  input  logic            clr_err,
  output logic [2*N-1:0]  phase,
  output logic [IW-1:0]   phase_idx,
  output logic            valid,
  output logic            locked,
  output logic            err,
  output logic [7:0]      err_cnt
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_TRACK    = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t           state_r;
  logic [IW-1:0]    prev_idx_r;
  logic [7:0]       run_r;
  logic [2*N-1:0]   phase_r;
  logic [IW-1:0]    phase_idx_r;
  logic             valid_r;
  logic             err_r;

  logic             legal_s;
  logic [IW-1:0]    idx_s;
  logic [IW-1:0]    nxt_s;
  logic             good_s;
  logic             stall_s;
  logic             skip_s;
  logic             bad_s;

  // Johnson code for phase k: k ones filling from bit 0, then zeros filling from bit 0.
  function automatic logic [N-1:0] code_of(input int k);
    logic [N-1:0] code_v;
    code_v = {N{1'b0}};
    for (int b = 0; b < N; b++) begin
      code_v[b] = (k <= N) ? (b < k) : (b >= (k - N));
    end
    return code_v;
  endfunction

  // Decode the sample and classify the step against the previous legal phase.
  always_comb begin
    logic match_v;
    match_v = 1'b0;
    legal_s = 1'b0;
    idx_s   = {IW{1'b0}};
    for (int k = 0; k < 2*N; k++) begin
      match_v = (q == code_of(k));
      legal_s = legal_s | match_v;
      idx_s   = idx_s | (match_v ? IW'(k) : {IW{1'b0}});
    end
    nxt_s   = (prev_idx_r == IW'(2*N-1)) ? {IW{1'b0}} : (prev_idx_r + IW'(1));
    good_s  = legal_s & (idx_s == nxt_s);
    stall_s = legal_s & (idx_s == prev_idx_r);
    skip_s  = legal_s & ~good_s & ~stall_s;
    case (state_r)
      ST_UNLOCKED:        bad_s = ~legal_s;
      ST_TRACK, ST_LOCKED: bad_s = ~legal_s | skip_s;
      default:            bad_s = ~legal_s;
    endcase
  end

  // Phase outputs, lock FSM and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_UNLOCKED;
      prev_idx_r  <= {IW{1'b0}};
      run_r       <= 8'd0;
      phase_r     <= {(2*N){1'b0}};
      phase_idx_r <= {IW{1'b0}};
      valid_r     <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (legal_s) begin
        phase_r     <= {{(2*N-1){1'b0}}, 1'b1} << idx_s;
        phase_idx_r <= idx_s;
        valid_r     <= 1'b1;
        prev_idx_r  <= idx_s;
      end else begin
        phase_r     <= {(2*N){1'b0}};
        valid_r     <= 1'b0;
      end

      case (state_r)
        ST_UNLOCKED: begin
          if (legal_s) begin
            state_r <= ST_TRACK;
            run_r   <= 8'd0;
          end
        end
        ST_TRACK: begin
          if (!legal_s) begin
            state_r <= ST_UNLOCKED;
          end else if (good_s) begin
            run_r <= run_r + 8'd1;
            if ((run_r + 8'd1) == 8'(LOCK_CNT)) begin
              state_r <= ST_LOCKED;
            end
          end else if (skip_s) begin
            run_r <= 8'd0;
          end
        end
        ST_LOCKED: begin
          if (!legal_s) begin
            state_r <= ST_UNLOCKED;
          end else if (skip_s) begin
            state_r <= ST_TRACK;
            run_r   <= 8'd0;
          end
        end
        default: begin
          state_r <= ST_UNLOCKED;
          run_r   <= 8'd0;
        end
      endcase

      // A bad event in the same cycle as clr_err keeps the flag set.
      if (bad_s) begin
        err_r <= 1'b1;
      end else if (clr_err) begin
        err_r <= 1'b0;
      end
    end
  end

`ifdef JOHNSON_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Saturating bad-event counter; clear and event together leaves a count of one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r <= 8'd0;
    end else if (clr_err) begin
      err_cnt_r <= bad_s ? 8'd1 : 8'd0;
    end else if (bad_s && (err_cnt_r != 8'd255)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = 8'd0;
`endif

  assign phase     = phase_r;
  assign phase_idx = phase_idx_r;
  assign valid     = valid_r;
  assign locked    = (state_r == ST_LOCKED);
  assign err       = err_r;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor (N=4, LOCK_CNT=4) with immediate-assertion checks.
module tb_johnson_phase_monitor;

  logic       clk;
  logic       rst;
  logic [3:0] q;
  logic       clr_err;
  logic [7:0] phase;
  logic [2:0] phase_idx;
  logic       valid;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;

  int tests;
  int fails;

  logic [3:0] codes [8];
  logic [7:0] exp_cnt;

  johnson_phase_monitor #(.N(4), .LOCK_CNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .q         (q),
    .clr_err   (clr_err),
    .phase     (phase),
    .phase_idx (phase_idx),
    .valid     (valid),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [3:0] c);
    q = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] ph, input logic [2:0] ix,
                           input logic v, input logic lk, input logic e);
    check({tag, ".phase"}, 32'(phase), 32'(ph));
    check({tag, ".idx"},   32'(phase_idx), 32'(ix));
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".locked"}, 32'(locked), 32'(lk));
    check({tag, ".err"},   32'(err), 32'(e));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0011; codes[3] = 4'b0111;
    codes[4] = 4'b1111; codes[5] = 4'b1110; codes[6] = 4'b1100; codes[7] = 4'b1000;
    rst = 1'b1;
    q = 4'b0000;
    clr_err = 1'b0;
    #2;
    check_all("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    check("reset.err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Two laps of the legal sequence; lock after the fourth good step (fifth code).
    for (int i = 0; i < 16; i++) begin
      apply(codes[i % 8]);
      check_all($sformatf("lap%0d", i), 8'h01 << (i % 8), 3'(i % 8), 1'b1, (i >= 4), 1'b0);
    end
    apply(4'b0000);
    check_all("wrap", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);

    // Stall at 0111 while locked, then resume.
    apply(4'b0001); apply(4'b0011); apply(4'b0111);
    for (int i = 0; i < 3; i++) begin
      apply(4'b0111);
      check_all($sformatf("stall%0d", i), 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
    end
    apply(4'b1111);
    check_all("resume", 8'h10, 3'd4, 1'b1, 1'b1, 1'b0);

    // Illegal code while locked.
    apply(4'b0101);
    check_all("illegal", 8'h00, 3'd4, 1'b0, 1'b0, 1'b1);
`ifdef JOHNSON_ERR_CNT_EN
    exp_cnt = 8'd1;
`else
    exp_cnt = 8'd0;
`endif
    check("illegal.err_cnt", 32'(err_cnt), 32'(exp_cnt));

    // clr_err with a legal code clears; re-lock from phase 5.
    clr_err = 1'b1;
    apply(4'b1110);
    clr_err = 1'b0;
    check_all("clr", 8'h20, 3'd5, 1'b1, 1'b0, 1'b0);
    check("clr.err_cnt", 32'(err_cnt), 32'd0);
    apply(4'b1100); apply(4'b1000); apply(4'b0000);
    check("relock_pre", 32'(locked), 32'd0);
    apply(4'b0001);
    check("relock", 32'(locked), 32'd1);

    // Skip 0011 -> 1110 while locked.
    apply(4'b0011);
    apply(4'b1110);
    check_all("skip", 8'h20, 3'd5, 1'b1, 1'b0, 1'b1);
`ifdef JOHNSON_ERR_CNT_EN
    exp_cnt = 8'd1;
`else
    exp_cnt = 8'd0;
`endif
    check("skip.err_cnt", 32'(err_cnt), 32'(exp_cnt));
    apply(4'b1100); apply(4'b1000); apply(4'b0000);
    check("skip_relock_pre", 32'(locked), 32'd0);
    apply(4'b0001);
    check("skip_relock", 32'(locked), 32'd1);

    // clr_err together with an illegal code: set wins.
    clr_err = 1'b1;
    apply(4'b1010);
    clr_err = 1'b0;
    check_all("clr_bad", 8'h00, 3'd1, 1'b0, 1'b0, 1'b1);
    check("clr_bad.err_cnt", 32'(err_cnt), 32'(exp_cnt));
    apply(4'b0100);
`ifdef JOHNSON_ERR_CNT_EN
    exp_cnt = 8'd2;
`else
    exp_cnt = 8'd0;
`endif
    check("bad2.err_cnt", 32'(err_cnt), 32'(exp_cnt));

    // Lock again with err still set, then reset asynchronously.
    apply(4'b0000); apply(4'b0001); apply(4'b0011); apply(4'b0111); apply(4'b1111);
    check_all("prereset", 8'h10, 3'd4, 1'b1, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    check("async_rst.err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fresh lock needs four new good steps.
    apply(4'b0001);
    check_all("post_rst", 8'h02, 3'd1, 1'b1, 1'b0, 1'b0);
    apply(4'b0011); apply(4'b0111); apply(4'b1111);
    check("post_rst_pre", 32'(locked), 32'd0);
    apply(4'b1110);
    check("post_rst_lock", 32'(locked), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/johnson_phase_monitor.md
# johnson_phase_monitor

Downstream consumer of the team's N-stage Johnson counter. Samples the counter's state vector every clock, decodes the 2N legal Johnson codes into a registered one-hot phase and a binary phase index, and checks that the sequence advances correctly. A lock FSM reports when the counter has run cleanly for a programmable number of steps. A sticky error flag catches illegal codes and skipped states.

## Interface
- `N`, default 4: number of Johnson counter stages; 2N legal codes.
- `LOCK_CNT`, default 4: consecutive good steps required to assert `locked`; range 1..255.
- `IW`, default `$clog2(2*N)`: phase index width; derived, do not override.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high; clears all state.
- `q`  in  N: Johnson counter state; bit 0 is the stage fed by the inverted MSB.
- `clr_err`  in  1: synchronous clear of `err` and `err_cnt`.
- `phase`  out  2N: one-hot decoded phase, registered.
- `phase_idx`  out  IW: binary phase index, registered.
- `valid`  out  1: the last sampled code was legal.
- `locked`  out  1: the sequence is locked.
- `err`  out  1: sticky error flag.
- `err_cnt`  out  8: saturating count of bad events. Always present; driven to 0 when the feature is compiled out.

## Operation
- Legal code k, for 0 ≤ k ≤ N: the low k bits are 1 and the rest are 0.
- Legal code k, for N < k < 2N: the low (k−N) bits are 0 and the rest are 1.
- For N=4 the legal sequence is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, giving idx 0..7.
- Any other code is illegal.
- Legal sample: `phase` = 1<<k, `phase_idx` = k, `valid` = 1, and `prev_idx` is updated.
- Illegal sample: `phase` = 0, `valid` = 0, and both `phase_idx` and `prev_idx` hold.
- Step classification, for a legal sample k:
  - good: k == (`prev_idx`+1) mod 2N. Wrap-around from 2N−1 to 0 is good.
  - stall: k == `prev_idx`. Neutral; covers a counter held in reset at 0000.
  - skip: any other k.
- An illegal sample is classified as illegal.
- FSM states are UNLOCKED, TRACK and LOCKED; `run` is an 8-bit good-step counter.
- UNLOCKED:
  - legal sample → TRACK, `run`=0.
  - illegal sample → stay.
  - No step classification in this state; `prev_idx` is simply loaded.
- TRACK:
  - good step → `run`++; if `run`+1 == LOCK_CNT → LOCKED.
  - stall → stay, `run` holds.
  - skip → stay, `run`=0, bad event.
  - illegal → UNLOCKED, bad event.
- LOCKED:
  - good step or stall → stay.
  - skip → TRACK, `run`=0, bad event.
  - illegal → UNLOCKED, bad event.
- An illegal sample in UNLOCKED also counts as a bad event.
- `locked` = 1 exactly while the state is LOCKED.
- `err` is set on any bad event and cleared by `clr_err`. If a bad event and `clr_err` occur in the same cycle, the set wins.

## Timing
- All outputs are registered. A sample of `q` at edge t is reflected on all outputs after edge t; latency is 1 cycle.
- `locked` rises on the same edge as the LOCK_CNT-th good step.
- `locked` falls on the same edge as the offending sample.
- `err` and `err_cnt` update on the same edge as the bad event.
- Reset values:
  - `phase`=0, `phase_idx`=0, `valid`=0, `locked`=0, `err`=0, `err_cnt`=0.
  - FSM state = UNLOCKED, `prev_idx`=0, `run`=0.
- Reset asserted mid-sequence clears everything immediately, without waiting for a clock edge.
- After reset deasserts, the first legal sample enters TRACK and lock needs LOCK_CNT fresh good steps.
- `q` is synchronous to `clk`; no input synchronizer is required.

## Configuration
- Macro `JOHNSON_ERR_CNT_EN`.
- Defined:
  - `err_cnt` is an 8-bit counter incremented on each bad event, saturating at 255.
  - `clr_err` sets it to 0; `clr_err` together with a bad event in the same cycle gives 1.
- Undefined: `err_cnt` is tied to 0 and no counter register is built. `err` behaviour is unchanged.

## Test plan
- Reset, then drive the legal 8-code sequence for N=4 (0000→…→1000→0000) for 2 laps:
  - `phase` goes 0x01, 0x02, …, 0x80, 0x01 with `phase_idx` 0..7.
  - `valid`=1 throughout.
  - `locked` rises on the 4th good step, 1 cycle after the 5th code is applied.
  - `err`=0.
- Once locked, hold `q`=0111 for 3 cycles, then resume with 1111: `locked` stays 1 and `err`=0.
- Once locked, inject 0101:
  - `phase`=0, `valid`=0, `phase_idx` holds.
  - `locked` falls on that edge and `err`=1.
  - `err_cnt`=1 with the macro, 0 without.
- Once locked, jump from 0011 to 1110:
  - State goes to TRACK, `locked` falls, `err`=1.
  - Re-lock happens after 4 further good steps.
- Assert `clr_err` on the same cycle as an illegal code: `err` stays 1 and `err_cnt`=1 with the macro.
- Assert `rst` asynchronously while locked with `err`=1: all outputs go to 0 before the next clock edge.
